serial_adder_ctrl: RTL



---
 rtl/serial_adder_ctrl.sv | 226 ++++++++++++++++++++++
 1 files changed

// File: rtl/serial_adder_ctrl.sv
// Purpose : bit-serial adder sequencer; time-shares one full adder over WIDTH steps
//           (LSB first) and drives a hex 7-segment display with the registered result.
// Latency : start accepted at edge E0; sum/cout update at edge E(WIDTH*DIV); done pulses
//           for one cycle after that; busy is high for WIDTH*DIV cycles.
// Backpressure: none; start is sampled only in IDLE and ignored (not queued) otherwise.
// Ports   : clk/rst (async active-high); start, op_a, op_b, cin in;
//           busy, done, sum, cout, seg (active-low g..a), dp (active-low, = !cout) out.
module serial_adder_ctrl #(
    parameter int WIDTH = 4,
    parameter int DIV   = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic [6:0]       seg,
    output logic             dp
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int PRE_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);
    localparam logic [PRE_W-1:0] LAST_PRE = PRE_W'(DIV - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ADD  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic [WIDTH-1:0] shift_a_q, shift_a_d;
    logic [WIDTH-1:0] shift_b_q, shift_b_d;
    logic [WIDTH-1:0] res_q,     res_d;
    logic [WIDTH-1:0] sum_q,     sum_d;
    logic             carry_q,   carry_d;
    logic             cout_q,    cout_d;
    logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
    logic [PRE_W-1:0] pre_q,     pre_d;

    logic             accept;
    logic             step;
    logic             last_step;
    logic             a0;
    logic             b0;
    logic             s_bit;
    logic             c_next;
    logic [WIDTH-1:0] res_shift;
    logic [3:0]       nib;

    // The single shared full adder.
    assign a0     = shift_a_q[0];
    assign b0     = shift_b_q[0];
    assign s_bit  = a0 ^ b0 ^ carry_q;
    assign c_next = (a0 & b0) | (b0 & carry_q) | (carry_q & a0);

    // New sum bit enters at the MSB so that after WIDTH steps the LSB-first
    // bits have settled into their natural positions.
    assign res_shift = (res_q >> 1) | (WIDTH'(s_bit) << (WIDTH - 1));

    assign accept    = (state_q == S_IDLE) && start;
    assign step      = (state_q == S_ADD) && (pre_q == LAST_PRE);
    assign last_step = step && (bit_cnt_q == LAST_BIT);

    //------------------------------------------------------------------
    // FSM: state register
    //------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    //------------------------------------------------------------------
    // FSM: next state
    //------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_ADD;
                end
            end
            S_ADD: begin
                if (last_step) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    //------------------------------------------------------------------
    // FSM: outputs
    //------------------------------------------------------------------
    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        unique case (state_q)
            S_ADD:   busy = 1'b1;
            S_DONE:  done = 1'b1;
            default: begin
                busy = 1'b0;
                done = 1'b0;
            end
        endcase
    end

    //------------------------------------------------------------------
    // Datapath next-state
    //------------------------------------------------------------------
    always_comb begin
        shift_a_d = shift_a_q;
        shift_b_d = shift_b_q;
        res_d     = res_q;
        carry_d   = carry_q;
        bit_cnt_d = bit_cnt_q;
        pre_d     = pre_q;
        sum_d     = sum_q;
        cout_d    = cout_q;

        if (accept) begin
            shift_a_d = op_a;
            shift_b_d = op_b;
            carry_d   = cin;
            bit_cnt_d = '0;
            pre_d     = '0;
            res_d     = '0;
        end else if (state_q == S_ADD) begin
            // Prescaler free-runs in ADD; a step happens on its wrap.
            if (pre_q == LAST_PRE) begin
                pre_d = '0;
            end else begin
                pre_d = pre_q + PRE_W'(1);
            end

            if (step) begin
                shift_a_d = shift_a_q >> 1;
                shift_b_d = shift_b_q >> 1;
                carry_d   = c_next;
                res_d     = res_shift;
                bit_cnt_d = bit_cnt_q + CNT_W'(1);
            end

            // Publish only on completion so the display holds the old result during ADD.
            if (last_step) begin
                sum_d  = res_shift;
                cout_d = c_next;
            end
        end
    end

    //------------------------------------------------------------------
    // Datapath registers
    //------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shift_a_q <= '0;
            shift_b_q <= '0;
            res_q     <= '0;
            carry_q   <= 1'b0;
            bit_cnt_q <= '0;
            pre_q     <= '0;
            sum_q     <= '0;
            cout_q    <= 1'b0;
        end else begin
            shift_a_q <= shift_a_d;
            shift_b_q <= shift_b_d;
            res_q     <= res_d;
            carry_q   <= carry_d;
            bit_cnt_q <= bit_cnt_d;
            pre_q     <= pre_d;
            sum_q     <= sum_d;
            cout_q    <= cout_d;
        end
    end

    assign sum  = sum_q;
    assign cout = cout_q;
    assign dp   = ~cout_q;

    //------------------------------------------------------------------
    // Hex display decode (active-low, bit order g..a)
    //------------------------------------------------------------------
    // Size cast zero-extends narrow results and truncates wide ones to the low nibble.
    assign nib = 4'(sum_q);

    always_comb begin
        seg = 7'b1000000;
        unique case (nib)
            4'h0: seg = 7'b1000000;
            4'h1: seg = 7'b1111001;
            4'h2: seg = 7'b0100100;
            4'h3: seg = 7'b0110000;
            4'h4: seg = 7'b0011001;
            4'h5: seg = 7'b0010010;
            4'h6: seg = 7'b0000010;
            4'h7: seg = 7'b1111000;
            4'h8: seg = 7'b0000000;
            4'h9: seg = 7'b0010000;
            4'hA: seg = 7'b0001000;
            4'hB: seg = 7'b0000011;
            4'hC: seg = 7'b1000110;
            4'hD: seg = 7'b0100001;
            4'hE: seg = 7'b0000110;
            4'hF: seg = 7'b0001110;
            default: seg = 7'b1000000;
        endcase
    end

endmodule
